mul_issue_ctl: RTL and testbench

MUL_ISSUE_CTL -- requirements
Module: mul_issue_ctl

---
 rtl/mul_ctl_pkg.sv | 76 +++++++
 rtl/mul_issue_ctl_if.sv | 65 ++++++
 rtl/mul_flag_reg.sv | 65 ++++++
 rtl/mul_issue_ctl.sv | 161 ++++++++++++++++
 tb/tb_mul_issue_ctl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_ctl_pkg.sv
// rtl/mul_ctl_pkg.sv - op codes, control encodings and op decode shared by the multiplier issue controller
package mul_ctl_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'b0000,
    OP_MUL     = 4'b0001,
    OP_MAC_ADD = 4'b0010,
    OP_MAC_SUB = 4'b0011,
    OP_RN_MR0  = 4'b0100,
    OP_RN_MR1  = 4'b0101,
    OP_RN_MR2  = 4'b0110,
    OP_MR0_RN  = 4'b0111,
    OP_MR1_RN  = 4'b1000,
    OP_MR2_RN  = 4'b1001,
    OP_SAT_MR  = 4'b1010
  } mul_op_e;

  // Multiplier operation class
  localparam logic [1:0] CLS_MOVE    = 2'b00;
  localparam logic [1:0] CLS_PRODUCT = 2'b01;
  localparam logic [1:0] CLS_MAC_ADD = 2'b10;
  localparam logic [1:0] CLS_MAC_SUB = 2'b11;

  // MR slice select for move-class ops; SC_SAT selects saturation of MR
  localparam logic [1:0] SC_MR0 = 2'b00;
  localparam logic [1:0] SC_MR1 = 2'b01;
  localparam logic [1:0] SC_MR2 = 2'b10;
  localparam logic [1:0] SC_SAT = 2'b11;

  // Bit positions inside dec_mul_dtsts / ps_mul_dtsts
  localparam int DTSTS_RND_PRDT = 0;
  localparam int DTSTS_IBF      = 1;
  localparam int DTSTS_RXUBS    = 2;
  localparam int DTSTS_RYUBS    = 3;

  // Execute-stage occupancy
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic       legal;
    logic       nop;
    logic [1:0] cls;
    logic [1:0] sc;
    logic       otreg_fixed;     // destination when the op itself fixes it
    logic       otreg_from_dec;  // destination taken from dec_mul_otreg
    logic       reads_rx;
    logic       reads_ry;
    logic       flag_op;         // op updates the multiplier status flags
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [3:0] op);
    op_dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_NOP:     d.nop = 1'b1;
      OP_MUL:     begin d.cls = CLS_PRODUCT; d.otreg_from_dec = 1'b1; d.reads_rx = 1'b1; d.reads_ry = 1'b1; end
      OP_MAC_ADD: begin d.cls = CLS_MAC_ADD; d.otreg_from_dec = 1'b1; d.reads_rx = 1'b1; d.reads_ry = 1'b1; end
      OP_MAC_SUB: begin d.cls = CLS_MAC_SUB; d.otreg_from_dec = 1'b1; d.reads_rx = 1'b1; d.reads_ry = 1'b1; end
      OP_RN_MR0:  d.sc = SC_MR0;
      OP_RN_MR1:  d.sc = SC_MR1;
      OP_RN_MR2:  d.sc = SC_MR2;
      OP_MR0_RN:  begin d.sc = SC_MR0; d.otreg_fixed = 1'b1; d.reads_rx = 1'b1; end
      OP_MR1_RN:  begin d.sc = SC_MR1; d.otreg_fixed = 1'b1; d.reads_rx = 1'b1; end
      OP_MR2_RN:  begin d.sc = SC_MR2; d.otreg_fixed = 1'b1; d.reads_rx = 1'b1; end
      OP_SAT_MR:  begin d.sc = SC_SAT; d.otreg_fixed = 1'b1; end
      default:    d.legal = 1'b0;
    endcase
    d.flag_op = d.legal && !d.nop && ((d.cls != CLS_MOVE) || (d.sc == SC_SAT));
    return d;
  endfunction

endpackage

// File: rtl/mul_issue_ctl_if.sv
// rtl/mul_issue_ctl_if.sv - decoder, multiplier, writeback and flag signals of the multiplier issue controller
interface mul_issue_ctl_if #(
  parameter int RF_ADDRSIZE = 4
);

  // decoder side
  logic                   dec_mul_vld;
  logic                   mul_dec_rdy;
  logic [3:0]             dec_mul_op;
  logic                   dec_mul_float;
  logic                   dec_mul_trunc;
  logic [3:0]             dec_mul_dtsts;
  logic                   dec_mul_otreg;
  logic                   dec_cond_pass;
  logic [RF_ADDRSIZE-1:0] dec_rx;
  logic [RF_ADDRSIZE-1:0] dec_ry;
  logic [RF_ADDRSIZE-1:0] dec_rd;

  // multiplier control
  logic                   ps_mul_en;
  logic                   ps_mul_float;
  logic                   ps_mul_otreg;
  logic                   ps_mul_trunc;
  logic [3:0]             ps_mul_dtsts;
  logic [1:0]             ps_mul_cls;
  logic [1:0]             ps_mul_sc;

  // multiplier flags
  logic                   mul_ps_mv;
  logic                   mul_ps_mn;
  logic                   mul_ps_mu;
  logic                   mul_ps_mi;

  // writeback and status
  logic                   wb_we;
  logic [RF_ADDRSIZE-1:0] wb_rd;
  logic                   astat_mv;
  logic                   astat_mn;
  logic                   astat_mu;
  logic                   astat_mi;
  logic                   stky_mv;
  logic                   stky_mu;
  logic                   stky_mi;
  logic                   stky_clr;
  logic                   illegal_op;

  modport master (
    output dec_mul_vld, dec_mul_op, dec_mul_float, dec_mul_trunc, dec_mul_dtsts,
           dec_mul_otreg, dec_cond_pass, dec_rx, dec_ry, dec_rd,
           mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi, stky_clr,
    input  mul_dec_rdy, ps_mul_en, ps_mul_float, ps_mul_otreg, ps_mul_trunc,
           ps_mul_dtsts, ps_mul_cls, ps_mul_sc, wb_we, wb_rd,
           astat_mv, astat_mn, astat_mu, astat_mi, stky_mv, stky_mu, stky_mi, illegal_op
  );

  modport slave (
    input  dec_mul_vld, dec_mul_op, dec_mul_float, dec_mul_trunc, dec_mul_dtsts,
           dec_mul_otreg, dec_cond_pass, dec_rx, dec_ry, dec_rd,
           mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi, stky_clr,
    output mul_dec_rdy, ps_mul_en, ps_mul_float, ps_mul_otreg, ps_mul_trunc,
           ps_mul_dtsts, ps_mul_cls, ps_mul_sc, wb_we, wb_rd,
           astat_mv, astat_mn, astat_mu, astat_mi, stky_mv, stky_mu, stky_mi, illegal_op
  );

endinterface

// File: rtl/mul_flag_reg.sv
// rtl/mul_flag_reg.sv - multiplier status flag capture with sticky accumulation
module mul_flag_reg (
  input  logic clk,
  input  logic reset,
  input  logic cap_i_i,      // flag op in its issue cycle: capture mi
  input  logic cap_e_i,      // flag op in its execute cycle: capture mv/mn/mu
  input  logic mv_i,
  input  logic mn_i,
  input  logic mu_i,
  input  logic mi_i,
  input  logic stky_clr_i,
  output logic astat_mv_o,
  output logic astat_mn_o,
  output logic astat_mu_o,
  output logic astat_mi_o,
  output logic stky_mv_o,
  output logic stky_mu_o,
  output logic stky_mi_o
);

  logic astat_mv_q, astat_mn_q, astat_mu_q, astat_mi_q;
  logic stky_mv_q, stky_mu_q, stky_mi_q;
  logic stky_mv_d, stky_mu_d, stky_mi_d;

  // Sticky next state: a capture of 1 wins over a simultaneous clear
  always_comb begin
    stky_mv_d = (stky_mv_q && !stky_clr_i) || (cap_e_i && mv_i);
    stky_mu_d = (stky_mu_q && !stky_clr_i) || (cap_e_i && mu_i);
    stky_mi_d = (stky_mi_q && !stky_clr_i) || (cap_i_i && mi_i);
  end

  // Capture architectural flags and update sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      astat_mv_q <= 1'b0;
      astat_mn_q <= 1'b0;
      astat_mu_q <= 1'b0;
      astat_mi_q <= 1'b0;
      stky_mv_q  <= 1'b0;
      stky_mu_q  <= 1'b0;
      stky_mi_q  <= 1'b0;
    end else begin
      if (cap_i_i) begin
        astat_mi_q <= mi_i;
      end
      if (cap_e_i) begin
        astat_mv_q <= mv_i;
        astat_mn_q <= mn_i;
        astat_mu_q <= mu_i;
      end
      stky_mv_q <= stky_mv_d;
      stky_mu_q <= stky_mu_d;
      stky_mi_q <= stky_mi_d;
    end
  end

  assign astat_mv_o = astat_mv_q;
  assign astat_mn_o = astat_mn_q;
  assign astat_mu_o = astat_mu_q;
  assign astat_mi_o = astat_mi_q;
  assign stky_mv_o  = stky_mv_q;
  assign stky_mu_o  = stky_mu_q;
  assign stky_mi_o  = stky_mi_q;

endmodule

// File: rtl/mul_issue_ctl.sv
// rtl/mul_issue_ctl.sv - multiplier issue controller: decode, RAW interlock, issue/execute pipeline, writeback
module mul_issue_ctl
  import mul_ctl_pkg::*;
#(
  parameter int RF_ADDRSIZE = 4
) (
  input  logic           clk,
  input  logic           reset,
  mul_issue_ctl_if.slave bus
);

  op_dec_t                dec;
  logic                   hazard;
  logic                   rdy;
  logic                   accept;
  logic                   issue;
  logic                   ps_otreg_d;
  logic [3:0]             ps_dtsts_d;

  // issue-cycle registers
  logic                   ps_mul_en_q;
  logic                   ps_mul_float_q;
  logic                   ps_mul_otreg_q;
  logic                   ps_mul_trunc_q;
  logic [3:0]             ps_mul_dtsts_q;
  logic [1:0]             ps_mul_cls_q;
  logic [1:0]             ps_mul_sc_q;
  logic [RF_ADDRSIZE-1:0] i_rd_q;
  logic                   i_flag_op_q;
  logic                   illegal_q;

  // execute-cycle registers
  pipe_state_e            state_q;
  logic                   e_flag_op_q;
  logic                   wb_we_q;
  logic [RF_ADDRSIZE-1:0] wb_rd_q;

  logic                   cap_i;
  logic                   cap_e;
  logic                   astat_mv, astat_mn, astat_mu, astat_mi;
  logic                   stky_mv, stky_mu, stky_mi;

  // Decode the op currently offered by the decoder
  always_comb dec = decode_op(bus.dec_mul_op);

  // RAW check against the Rn-writing op sitting in its issue cycle; its
  // result lands in the execute cycle, so a single bubble covers it
  always_comb begin
    hazard = 1'b0;
    if (bus.dec_mul_vld && ps_mul_en_q && !ps_mul_otreg_q) begin
      if (dec.reads_rx && (bus.dec_rx == i_rd_q)) hazard = 1'b1;
      if (dec.reads_ry && (bus.dec_ry == i_rd_q)) hazard = 1'b1;
    end
  end

  // Ready depends only on reset, the decoder inputs and registered state
  assign rdy    = reset && !hazard;
  assign accept = bus.dec_mul_vld && rdy;
  assign issue  = accept && bus.dec_cond_pass && dec.legal && !dec.nop;

  // Destination select and data-type status for the op being issued
  always_comb begin
    ps_otreg_d = dec.otreg_fixed;
    if (dec.otreg_from_dec) ps_otreg_d = bus.dec_mul_otreg;
    ps_dtsts_d                 = '0;
    ps_dtsts_d[DTSTS_RND_PRDT] = bus.dec_mul_dtsts[DTSTS_RND_PRDT];
    ps_dtsts_d[DTSTS_IBF]      = bus.dec_mul_dtsts[DTSTS_IBF];
    ps_dtsts_d[DTSTS_RXUBS]    = bus.dec_mul_dtsts[DTSTS_RXUBS];
    ps_dtsts_d[DTSTS_RYUBS]    = bus.dec_mul_dtsts[DTSTS_RYUBS];
  end

  // Issue stage: enable pulses one cycle per issued op, control fields hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_mul_en_q    <= 1'b0;
      ps_mul_float_q <= 1'b0;
      ps_mul_otreg_q <= 1'b0;
      ps_mul_trunc_q <= 1'b0;
      ps_mul_dtsts_q <= '0;
      ps_mul_cls_q   <= '0;
      ps_mul_sc_q    <= '0;
      i_rd_q         <= '0;
      i_flag_op_q    <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      ps_mul_en_q <= issue;
      illegal_q   <= accept && !dec.legal;
      if (issue) begin
        ps_mul_float_q <= bus.dec_mul_float;
        ps_mul_otreg_q <= ps_otreg_d;
        ps_mul_trunc_q <= bus.dec_mul_trunc;
        ps_mul_dtsts_q <= ps_dtsts_d;
        ps_mul_cls_q   <= dec.cls;
        ps_mul_sc_q    <= dec.sc;
        i_rd_q         <= bus.dec_rd;
        i_flag_op_q    <= dec.flag_op;
      end
    end
  end

  // Execute-stage FSM with registered writeback outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      e_flag_op_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      e_flag_op_q <= ps_mul_en_q && i_flag_op_q;
      wb_we_q     <= ps_mul_en_q && !ps_mul_otreg_q;
      if (ps_mul_en_q) wb_rd_q <= i_rd_q;
      case (state_q)
        ST_IDLE: if (ps_mul_en_q)  state_q <= ST_EXEC;
        ST_EXEC: if (!ps_mul_en_q) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cap_i = ps_mul_en_q && i_flag_op_q;
  assign cap_e = (state_q == ST_EXEC) && e_flag_op_q;

  mul_flag_reg u_flag_reg (
    .clk        (clk),
    .reset      (reset),
    .cap_i_i    (cap_i),
    .cap_e_i    (cap_e),
    .mv_i       (bus.mul_ps_mv),
    .mn_i       (bus.mul_ps_mn),
    .mu_i       (bus.mul_ps_mu),
    .mi_i       (bus.mul_ps_mi),
    .stky_clr_i (bus.stky_clr),
    .astat_mv_o (astat_mv),
    .astat_mn_o (astat_mn),
    .astat_mu_o (astat_mu),
    .astat_mi_o (astat_mi),
    .stky_mv_o  (stky_mv),
    .stky_mu_o  (stky_mu),
    .stky_mi_o  (stky_mi)
  );

  assign bus.mul_dec_rdy  = rdy;
  assign bus.ps_mul_en    = ps_mul_en_q;
  assign bus.ps_mul_float = ps_mul_float_q;
  assign bus.ps_mul_otreg = ps_mul_otreg_q;
  assign bus.ps_mul_trunc = ps_mul_trunc_q;
  assign bus.ps_mul_dtsts = ps_mul_dtsts_q;
  assign bus.ps_mul_cls   = ps_mul_cls_q;
  assign bus.ps_mul_sc    = ps_mul_sc_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.astat_mv     = astat_mv;
  assign bus.astat_mn     = astat_mn;
  assign bus.astat_mu     = astat_mu;
  assign bus.astat_mi     = astat_mi;
  assign bus.stky_mv      = stky_mv;
  assign bus.stky_mu      = stky_mu;
  assign bus.stky_mi      = stky_mi;
  assign bus.illegal_op   = illegal_q;

endmodule

// File: tb/tb_mul_issue_ctl.sv
// tb/tb_mul_issue_ctl.sv - self-checking bench for mul_issue_ctl against an op-level reference model
module tb_mul_issue_ctl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_issue_ctl_if #(.RF_ADDRSIZE(4)) bus ();

  mul_issue_ctl #(.RF_ADDRSIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op table: what each code means architecturally
  typedef struct packed {
    logic       legal;
    logic       nop;
    logic       rrx;
    logic       rry;
    logic       otf;   // destination comes from dec_mul_otreg
    logic       ofix;  // destination otherwise
    logic       flag;  // updates status flags
    logic [1:0] cls;
    logic [1:0] sc;
  } tdec_t;

  function automatic tdec_t tb_decode(input logic [3:0] op);
    tdec_t t;
    t = '0;
    t.legal = 1'b1;
    case (op)
      4'd0:  t.nop = 1'b1;
      4'd1:  begin t.cls = 2'd1; t.rrx = 1; t.rry = 1; t.otf = 1; t.flag = 1; end
      4'd2:  begin t.cls = 2'd2; t.rrx = 1; t.rry = 1; t.otf = 1; t.flag = 1; end
      4'd3:  begin t.cls = 2'd3; t.rrx = 1; t.rry = 1; t.otf = 1; t.flag = 1; end
      4'd4:  t.sc = 2'd0;
      4'd5:  t.sc = 2'd1;
      4'd6:  t.sc = 2'd2;
      4'd7:  begin t.sc = 2'd0; t.ofix = 1; t.rrx = 1; end
      4'd8:  begin t.sc = 2'd1; t.ofix = 1; t.rrx = 1; end
      4'd9:  begin t.sc = 2'd2; t.ofix = 1; t.rrx = 1; end
      4'd10: begin t.sc = 2'd3; t.ofix = 1; t.flag = 1; end
      default: t.legal = 1'b0;
    endcase
    return t;
  endfunction

  // model state: op in issue cycle, op in execute cycle, visible outputs
  logic       m_i_v, m_i_flag;
  logic [3:0] m_i_rd;
  logic       m_e_v, m_e_flag;
  logic       m_float, m_trunc, m_otreg;
  logic [3:0] m_dtsts;
  logic [1:0] m_cls, m_sc;
  logic       m_wb_we;
  logic [3:0] m_wb_rd;
  logic       m_ill;
  logic       m_a_mv, m_a_mn, m_a_mu, m_a_mi;
  logic       m_s_mv, m_s_mu, m_s_mi;

  task automatic model_clear();
    m_i_v = 0; m_i_flag = 0; m_i_rd = 0; m_e_v = 0; m_e_flag = 0;
    m_float = 0; m_trunc = 0; m_otreg = 0; m_dtsts = 0; m_cls = 0; m_sc = 0;
    m_wb_we = 0; m_wb_rd = 0; m_ill = 0;
    m_a_mv = 0; m_a_mn = 0; m_a_mu = 0; m_a_mi = 0;
    m_s_mv = 0; m_s_mu = 0; m_s_mi = 0;
  endtask

  function automatic logic model_rdy();
    tdec_t t;
    logic  raw;
    t = tb_decode(bus.dec_mul_op);
    raw = bus.dec_mul_vld && m_i_v && !m_otreg &&
          ((t.rrx && bus.dec_rx == m_i_rd) || (t.rry && bus.dec_ry == m_i_rd));
    return reset && !raw;
  endfunction

  task automatic model_step();
    tdec_t t;
    logic  acc, set_mv, set_mu, set_mi;
    acc = bus.dec_mul_vld && model_rdy();
    if (!reset) begin
      model_clear();
    end else begin
      set_mv = 0; set_mu = 0; set_mi = 0;
      if (m_i_v && m_i_flag) begin
        m_a_mi = bus.mul_ps_mi;
        set_mi = bus.mul_ps_mi;
      end
      if (m_e_v && m_e_flag) begin
        m_a_mv = bus.mul_ps_mv;
        m_a_mn = bus.mul_ps_mn;
        m_a_mu = bus.mul_ps_mu;
        set_mv = bus.mul_ps_mv;
        set_mu = bus.mul_ps_mu;
      end
      m_s_mv = (bus.stky_clr ? 1'b0 : m_s_mv) | set_mv;
      m_s_mu = (bus.stky_clr ? 1'b0 : m_s_mu) | set_mu;
      m_s_mi = (bus.stky_clr ? 1'b0 : m_s_mi) | set_mi;
      m_wb_we = m_i_v && !m_otreg;
      if (m_i_v) m_wb_rd = m_i_rd;
      m_e_v = m_i_v;
      m_e_flag = m_i_flag;
      t = tb_decode(bus.dec_mul_op);
      m_ill = acc && !t.legal;
      m_i_v = acc && bus.dec_cond_pass && t.legal && !t.nop;
      if (m_i_v) begin
        m_cls = t.cls;
        m_sc = t.sc;
        m_otreg = t.otf ? bus.dec_mul_otreg : t.ofix;
        m_float = bus.dec_mul_float;
        m_trunc = bus.dec_mul_trunc;
        m_dtsts = bus.dec_mul_dtsts;
        m_i_rd = bus.dec_rd;
        m_i_flag = t.flag;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("mul_dec_rdy", 32'(bus.mul_dec_rdy), 32'(model_rdy()));
    chk("ps_mul_en", 32'(bus.ps_mul_en), 32'(m_i_v));
    chk("ps_mul_cls", 32'(bus.ps_mul_cls), 32'(m_cls));
    chk("ps_mul_sc", 32'(bus.ps_mul_sc), 32'(m_sc));
    chk("ps_mul_otreg", 32'(bus.ps_mul_otreg), 32'(m_otreg));
    chk("ps_mul_float", 32'(bus.ps_mul_float), 32'(m_float));
    chk("ps_mul_trunc", 32'(bus.ps_mul_trunc), 32'(m_trunc));
    chk("ps_mul_dtsts", 32'(bus.ps_mul_dtsts), 32'(m_dtsts));
    chk("wb_we", 32'(bus.wb_we), 32'(m_wb_we));
    chk("wb_rd", 32'(bus.wb_rd), 32'(m_wb_rd));
    chk("illegal_op", 32'(bus.illegal_op), 32'(m_ill));
    chk("astat", 32'({bus.astat_mv, bus.astat_mn, bus.astat_mu, bus.astat_mi}),
        32'({m_a_mv, m_a_mn, m_a_mu, m_a_mi}));
    chk("stky", 32'({bus.stky_mv, bus.stky_mu, bus.stky_mi}), 32'({m_s_mv, m_s_mu, m_s_mi}));
  endtask

  // one clock: compare on the falling edge, advance the model, step past the rising edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_mul_vld = 0; bus.dec_mul_op = 0; bus.dec_mul_float = 0; bus.dec_mul_trunc = 0;
    bus.dec_mul_dtsts = 0; bus.dec_mul_otreg = 0; bus.dec_cond_pass = 1;
    bus.dec_rx = 0; bus.dec_ry = 0; bus.dec_rd = 0;
    bus.mul_ps_mv = 0; bus.mul_ps_mn = 0; bus.mul_ps_mu = 0; bus.mul_ps_mi = 0;
    bus.stky_clr = 0;
  endtask

  task automatic op(input logic [3:0] code, input logic [3:0] rx, input logic [3:0] ry,
                    input logic [3:0] rd, input logic cond);
    idle();
    bus.dec_mul_vld = 1; bus.dec_mul_op = code; bus.dec_rx = rx; bus.dec_ry = ry;
    bus.dec_rd = rd; bus.dec_cond_pass = cond;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    chk("rst_ps_mul_en", 32'(bus.ps_mul_en), 0);
    chk("rst_wb_we", 32'(bus.wb_we), 0);
    chk("rst_rdy", 32'(bus.mul_dec_rdy), 0);
    chk("rst_stky", 32'({bus.stky_mv, bus.stky_mu, bus.stky_mi}), 0);
    tick();
    reset = 1;
    tick();

    // product rd=3: issue next cycle, writeback the cycle after
    op(4'd1, 4'd1, 4'd2, 4'd3, 1);
    tick();
    chk("p_en", 32'(bus.ps_mul_en), 1);
    chk("p_cls", 32'(bus.ps_mul_cls), 32'h1);
    idle();
    tick();
    chk("p_wb_we", 32'(bus.wb_we), 1);
    chk("p_wb_rd", 32'(bus.wb_rd), 3);
    tick();

    // product rd=5 then MAC reading r5: one bubble
    op(4'd1, 4'd1, 4'd2, 4'd5, 1);
    tick();
    op(4'd2, 4'd5, 4'd0, 4'd6, 1);
    #1;
    chk("raw_rdy0", 32'(bus.mul_dec_rdy), 0);
    tick();
    #1;
    chk("raw_rdy1", 32'(bus.mul_dec_rdy), 1);
    tick();
    chk("raw_mac_en", 32'(bus.ps_mul_en), 1);
    chk("raw_mac_cls", 32'(bus.ps_mul_cls), 32'h2);
    idle();
    repeat (3) tick();

    // SAT MR sets mv; a following Rn=MR1 leaves it alone
    op(4'd10, 4'd0, 4'd0, 4'd0, 1);
    tick();
    idle();
    tick();
    bus.mul_ps_mv = 1;
    tick();
    chk("sat_astat_mv", 32'(bus.astat_mv), 1);
    chk("sat_stky_mv", 32'(bus.stky_mv), 1);
    op(4'd5, 4'd0, 4'd0, 4'd2, 1);
    tick();
    idle();
    repeat (2) tick();
    chk("mv_hold", 32'(bus.astat_mv), 1);

    // clear colliding with a new capture resolves to set, clear alone clears
    op(4'd10, 4'd0, 4'd0, 4'd0, 1);
    tick();
    idle();
    tick();
    bus.mul_ps_mv = 1;
    bus.stky_clr = 1;
    tick();
    chk("clr_set_stky_mv", 32'(bus.stky_mv), 1);
    idle();
    bus.stky_clr = 1;
    tick();
    chk("clr_stky_mv", 32'(bus.stky_mv), 0);
    idle();

    // illegal op and squashed product
    op(4'd15, 4'd0, 4'd0, 4'd0, 1);
    tick();
    chk("ill_pulse", 32'(bus.illegal_op), 1);
    chk("ill_no_en", 32'(bus.ps_mul_en), 0);
    idle();
    tick();
    chk("ill_once", 32'(bus.illegal_op), 0);
    op(4'd1, 4'd0, 4'd0, 4'd7, 0);
    tick();
    chk("sq_no_en", 32'(bus.ps_mul_en), 0);
    idle();
    tick();
    chk("sq_no_wb", 32'(bus.wb_we), 0);
    tick();
    chk("sq_astat", 32'(bus.astat_mv), 1);

    // reset during execute abandons the product
    op(4'd1, 4'd0, 4'd0, 4'd4, 1);
    tick();
    idle();
    bus.mul_ps_mv = 1;
    tick();
    reset = 0;
    tick();
    chk("rse_wb_we", 32'(bus.wb_we), 0);
    chk("rse_astat", 32'({bus.astat_mv, bus.astat_mn, bus.astat_mu, bus.astat_mi}), 0);
    chk("rse_stky", 32'({bus.stky_mv, bus.stky_mu, bus.stky_mi}), 0);
    reset = 1;
    op(4'd1, 4'd4, 4'd4, 4'd1, 1);
    #1;
    chk("rse_rdy", 32'(bus.mul_dec_rdy), 1);
    tick();
    idle();
    repeat (2) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.dec_mul_vld    = ($urandom_range(0, 99) < 75);
      bus.dec_mul_op     = 4'($urandom_range(0, 15));
      bus.dec_mul_float  = 1'($urandom_range(0, 1));
      bus.dec_mul_trunc  = 1'($urandom_range(0, 1));
      bus.dec_mul_dtsts  = 4'($urandom_range(0, 15));
      bus.dec_mul_otreg  = 1'($urandom_range(0, 1));
      bus.dec_cond_pass  = ($urandom_range(0, 9) != 0);
      bus.dec_rx         = 4'($urandom_range(0, 3));
      bus.dec_ry         = 4'($urandom_range(0, 3));
      bus.dec_rd         = 4'($urandom_range(0, 3));
      bus.mul_ps_mv      = 1'($urandom_range(0, 1));
      bus.mul_ps_mn      = 1'($urandom_range(0, 1));
      bus.mul_ps_mu      = 1'($urandom_range(0, 1));
      bus.mul_ps_mi      = 1'($urandom_range(0, 1));
      bus.stky_clr       = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
